tx_frame_serializer: RTL and testbench

Transmit-side framing stage directly downstream of the TXRX transmit byte FIFO. On a start request it emits a frame bit-serially: preamble bytes, start-of-frame delimiter, length byte, then payload bytes. Payload bytes are popped from the FIFO's show-ahead read port (data valid whenever not empty; rd_en advances). Bit rate is a fixed integer division of the system clock.

---
 rtl/tx_frame_serializer.sv | 194 +++++++++++++++++++
 tb/tb_tx_frame_serializer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_serializer.sv
// Bit-serial frame transmitter: preamble, SFD, length byte, then payload popped from a show-ahead FIFO.
// Define TXRX_TX_CRC_EN to append a CRC-16/CCITT (MSB first) covering the length and payload fields.
module tx_frame_serializer #(
  parameter int         CLK_DIV        = 4,
  parameter int         PREAMBLE_BYTES = 4,
  parameter logic [7:0] SFD            = 8'hA7,
  parameter int         DATA_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            len,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  tx_bit,
  output logic                  tx_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0]       PRE_LAST = 8'(PREAMBLE_BYTES);
  localparam logic [7:0]       PRE_BYTE = 8'hAA;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD_S,
    LEN_S,
    PAYLOAD,
`ifdef TXRX_TX_CRC_EN
    CRC_S,
`endif
    DONE_S
  } state_t;

  state_t           state_r;
  logic [7:0]       len_r;
  logic [7:0]       sh_r;
  logic [7:0]       byte_cnt_r;
  logic [3:0]       bit_cnt_r;
  logic [DIV_W-1:0] div_r;
  logic             fifo_rd_en_r;
  logic             tx_valid_r;
  logic             busy_r;
  logic             done_r;
  logic             underrun_r;
  logic             wrap_s;
  logic             byte_end_s;

`ifdef TXRX_TX_CRC_EN
  logic [15:0] crc_r;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign tx_bit = tx_valid_r & ((state_r == CRC_S) ? crc_r[15] : sh_r[0]);
`else
  assign tx_bit = tx_valid_r & sh_r[0];
`endif

  assign wrap_s     = (div_r == DIV_LAST);
  assign byte_end_s = wrap_s && (bit_cnt_r == 4'd7);
  assign fifo_rd_en = fifo_rd_en_r;
  assign tx_valid   = tx_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign underrun   = underrun_r;

  // Frame sequencer: bit timing, byte loading, FIFO pops and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      len_r        <= 8'd0;
      sh_r         <= 8'd0;
      byte_cnt_r   <= 8'd0;
      bit_cnt_r    <= 4'd0;
      div_r        <= '0;
      fifo_rd_en_r <= 1'b0;
      tx_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      underrun_r   <= 1'b0;
`ifdef TXRX_TX_CRC_EN
      crc_r        <= 16'hFFFF;
`endif
    end else begin
      fifo_rd_en_r <= 1'b0;
      done_r       <= 1'b0;
      underrun_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            len_r      <= len;
            sh_r       <= PRE_BYTE;
            byte_cnt_r <= 8'd1;
            bit_cnt_r  <= 4'd0;
            div_r      <= '0;
            tx_valid_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= PREAMBLE;
`ifdef TXRX_TX_CRC_EN
            crc_r      <= 16'hFFFF;
`endif
          end
        end
        PREAMBLE, SFD_S, LEN_S, PAYLOAD: begin
          div_r <= wrap_s ? '0 : div_r + DIV_W'(1);
          if (wrap_s) begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
            sh_r      <= {1'b0, sh_r[7:1]};
`ifdef TXRX_TX_CRC_EN
            if (state_r == LEN_S || state_r == PAYLOAD) begin
              crc_r <= crc_step(crc_r, sh_r[0]);
            end
`endif
          end
          // Next byte is loaded on the last divider cycle of bit 7, so bytes abut.
          if (byte_end_s) begin
            bit_cnt_r <= 4'd0;
            case (state_r)
              PREAMBLE: begin
                if (byte_cnt_r == PRE_LAST) begin
                  sh_r       <= SFD;
                  byte_cnt_r <= 8'd0;
                  state_r    <= SFD_S;
                end else begin
                  sh_r       <= PRE_BYTE;
                  byte_cnt_r <= byte_cnt_r + 8'd1;
                end
              end
              SFD_S: begin
                sh_r    <= len_r;
                state_r <= LEN_S;
              end
              default: begin
                // byte_cnt_r is 0 in LEN_S, so a zero length ends here too.
                if (byte_cnt_r == len_r) begin
`ifdef TXRX_TX_CRC_EN
                  state_r    <= CRC_S;
`else
                  state_r    <= DONE_S;
                  tx_valid_r <= 1'b0;
                  done_r     <= 1'b1;
`endif
                end else if (fifo_empty) begin
                  state_r    <= IDLE;
                  tx_valid_r <= 1'b0;
                  busy_r     <= 1'b0;
                  underrun_r <= 1'b1;
                end else begin
                  sh_r         <= fifo_data[7:0];
                  fifo_rd_en_r <= 1'b1;
                  byte_cnt_r   <= byte_cnt_r + 8'd1;
                  state_r      <= PAYLOAD;
                end
              end
            endcase
          end
        end
`ifdef TXRX_TX_CRC_EN
        CRC_S: begin
          div_r <= wrap_s ? '0 : div_r + DIV_W'(1);
          if (wrap_s) begin
            crc_r     <= {crc_r[14:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd15) begin
              state_r    <= DONE_S;
              tx_valid_r <= 1'b0;
              done_r     <= 1'b1;
            end
          end
        end
`endif
        DONE_S: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Self-checking bench for tx_frame_serializer: a FIFO model plus a byte-level frame/CRC reference.
module tb_tx_frame_serializer;

  localparam int CLK_DIV = 4;
  localparam int PRE     = 2;
`ifdef TXRX_TX_CRC_EN
  localparam int CRC_CYC = 16 * CLK_DIV;
`else
  localparam int CRC_CYC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len_in;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd_en, tx_bit, tx_valid, busy, done, underrun;

  tx_frame_serializer #(.CLK_DIV(CLK_DIV), .PREAMBLE_BYTES(PRE), .SFD(8'hA7), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len_in), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model: head advances on each pop.
  logic [7:0] mem [0:63];
  int         head  = 0;
  int         tail  = 0;
  logic       flush = 1'b0;
  always @(posedge clk) begin
    if (flush) head <= tail;
    else if (fifo_rd_en && head != tail) head <= head + 1;
  end
  assign fifo_empty = (head == tail);
  assign fifo_data  = mem[head[5:0]];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] pl [0:255];
  int   np;
  logic exp_bits [0:4095];
  int   exp_n;
  logic cap [0:8191];
  int   m_tv, m_pops, m_done, m_under, m_bad, m_done_cyc, m_idle_cyc;
  logic m_timeout;

  task automatic push(input logic [7:0] b);
    mem[tail[5:0]] = b;
    pl[np] = b;
    np++;
    tail++;
  endtask

  task automatic load_random(input int n);
    np = 0;
    for (int i = 0; i < n; i++) push(8'($urandom));
  endtask

  // Reference frame: byte list serialised LSB first, CRC over length+payload bits.
  task automatic build_exp(input int l);
    logic [7:0]  fr [0:299];
    int          nf = 0;
    int          nsent;
    logic [15:0] crc = 16'hFFFF;
    logic        b, fb;
    nsent = (np < l) ? np : l;
    for (int p = 0; p < PRE; p++) begin fr[nf] = 8'hAA; nf++; end
    fr[nf] = 8'hA7; nf++;
    fr[nf] = 8'(l); nf++;
    for (int i = 0; i < nsent; i++) begin fr[nf] = pl[i]; nf++; end
    exp_n = 0;
    for (int i = 0; i < nf; i++) begin
      for (int k = 0; k < 8; k++) begin
        b = fr[i][k];
        exp_bits[exp_n] = b;
        exp_n++;
        if (i >= PRE + 1) begin
          fb  = crc[15] ^ b;
          crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
      end
    end
`ifdef TXRX_TX_CRC_EN
    if (nsent == l) begin
      for (int k = 0; k < 16; k++) begin exp_bits[exp_n] = crc[15-k]; exp_n++; end
    end
`endif
  endtask

  task automatic monitor_until_idle();
    m_tv = 0; m_pops = 0; m_done = 0; m_under = 0; m_done_cyc = -1; m_idle_cyc = -1;
    for (int c = 0; c < 20000; c++) begin
      if (tx_valid && m_tv < 8192) begin cap[m_tv] = tx_bit; m_tv++; end
      if (fifo_rd_en) m_pops++;
      if (done) begin m_done++; m_done_cyc = c; end
      if (underrun) m_under++;
      if (!busy) begin m_idle_cyc = c; break; end
      @(negedge clk);
    end
    m_timeout = busy;
    m_bad = 0;
    for (int i = 0; i < m_tv && i < exp_n * CLK_DIV; i++)
      if (cap[i] !== exp_bits[i / CLK_DIV]) m_bad++;
  endtask

  task automatic run_frame(input int l);
    @(negedge clk);
    len_in = 8'(l);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    monitor_until_idle();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; len_in = 8'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({fifo_rd_en, tx_bit, tx_valid, busy, done, underrun} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 000000",
                         {fifo_rd_en, tx_bit, tx_valid, busy, done, underrun});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tx_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_idle: got %b expected 00", {tx_valid, busy});
    end
  endtask

  task automatic test_basic();
    np = 0; push(8'h01); push(8'h80);
    build_exp(2);
    run_frame(2);
    n_checks++;
    if (m_tv !== (PRE + 2 + 2) * 8 * CLK_DIV + CRC_CYC) begin
      n_fail++; $display("FAIL basic_tv_cycles: got %0d expected %0d", m_tv, (PRE + 4) * 8 * CLK_DIV + CRC_CYC);
    end
    n_checks++;
    if (m_bad !== 0) begin n_fail++; $display("FAIL basic_bits: got %0d wrong samples expected 0", m_bad); end
    n_checks++;
    if (m_pops !== 2) begin n_fail++; $display("FAIL basic_pops: got %0d expected 2", m_pops); end
    n_checks++;
    if (m_done !== 1 || m_under !== 0) begin
      n_fail++; $display("FAIL basic_status: got done=%0d underrun=%0d expected 1/0", m_done, m_under);
    end
    n_checks++;
    if (m_timeout !== 1'b0 || m_idle_cyc !== m_done_cyc + 1) begin
      n_fail++; $display("FAIL basic_busy_after_done: got idle@%0d done@%0d expected idle one cycle after done",
                         m_idle_cyc, m_done_cyc);
    end
  endtask

  task automatic test_len_zero();
    np = 0;
    build_exp(0);
    run_frame(0);
    n_checks++;
    if (m_tv !== 32 * CLK_DIV + CRC_CYC) begin
      n_fail++; $display("FAIL len0_tv_cycles: got %0d expected %0d", m_tv, 32 * CLK_DIV + CRC_CYC);
    end
    n_checks++;
    if (m_bad !== 0) begin n_fail++; $display("FAIL len0_bits: got %0d wrong samples expected 0", m_bad); end
    n_checks++;
    if (m_pops !== 0 || m_done !== 1) begin
      n_fail++; $display("FAIL len0_status: got pops=%0d done=%0d expected 0/1", m_pops, m_done);
    end
  endtask

  task automatic test_random();
    int l;
    for (int f = 0; f < 4; f++) begin
      l = int'($urandom_range(1, 6));
      load_random(l);
      build_exp(l);
      run_frame(l);
      n_checks++;
      if (m_tv !== exp_n * CLK_DIV || m_bad !== 0) begin
        n_fail++; $display("FAIL rand%0d_frame: got %0d cycles %0d bad expected %0d cycles 0 bad",
                           f, m_tv, m_bad, exp_n * CLK_DIV);
      end
      n_checks++;
      if (m_pops !== l || m_done !== 1 || m_under !== 0 || m_timeout !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_status: got pops=%0d done=%0d underrun=%0d expected %0d/1/0",
                           f, m_pops, m_done, m_under, l);
      end
    end
  endtask

  task automatic test_underrun();
    load_random(2);
    build_exp(3);
    run_frame(3);
    n_checks++;
    if (m_tv !== (PRE + 4) * 8 * CLK_DIV || m_bad !== 0) begin
      n_fail++; $display("FAIL underrun_frame: got %0d cycles %0d bad expected %0d cycles 0 bad",
                         m_tv, m_bad, (PRE + 4) * 8 * CLK_DIV);
    end
    n_checks++;
    if (m_pops !== 2 || m_under !== 1 || m_done !== 0) begin
      n_fail++; $display("FAIL underrun_status: got pops=%0d underrun=%0d done=%0d expected 2/1/0",
                         m_pops, m_under, m_done);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, tx_valid, underrun} !== 3'b000) begin
      n_fail++; $display("FAIL underrun_idle: got %b expected 000", {busy, tx_valid, underrun});
    end
  endtask

  task automatic test_async_reset();
    logic seen = 1'b0;
    load_random(3);
    @(negedge clk); len_in = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (fifo_rd_en) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL areset_reach_payload: got no pop expected a pop"); end
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({fifo_rd_en, tx_bit, tx_valid, busy, done, underrun} !== 6'b0) begin
      n_fail++; $display("FAIL areset_outputs: got %b expected 000000",
                         {fifo_rd_en, tx_bit, tx_valid, busy, done, underrun});
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rst = 1'b1;
    load_random(1);
    build_exp(1);
    run_frame(1);
    n_checks++;
    if (m_tv !== exp_n * CLK_DIV || m_bad !== 0 || m_pops !== 1 || m_done !== 1) begin
      n_fail++; $display("FAIL areset_clean_frame: got %0d cycles %0d bad pops=%0d done=%0d expected %0d/0/1/1",
                         m_tv, m_bad, m_pops, m_done, exp_n * CLK_DIV);
    end
  endtask

  task automatic test_back_to_back();
    int frames = 0, dones = 0, tv = 0, drop_at = -1;
    logic prev_tv = 1'b0;
    np = 0;
    build_exp(0);
    @(negedge clk); len_in = 8'd0; start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (tx_valid && !prev_tv) frames++;
      prev_tv = tx_valid;
      if (tx_valid) tv++;
      if (done) begin dones++; if (dones == 1) drop_at = c + 2; end
      if (c == drop_at) start = 1'b0;
      if (drop_at >= 0 && c == drop_at + 40) start = 1'b1;
      if (drop_at >= 0 && c == drop_at + 41) start = 1'b0;
      if (dones == 2 && !busy) break;
    end
    start = 1'b0;
    n_checks++;
    if (frames !== 2 || dones !== 2) begin
      n_fail++; $display("FAIL b2b_frames: got frames=%0d dones=%0d expected 2/2", frames, dones);
    end
    n_checks++;
    if (tv !== 2 * exp_n * CLK_DIV) begin
      n_fail++; $display("FAIL b2b_tv_cycles: got %0d expected %0d", tv, 2 * exp_n * CLK_DIV);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stays_idle: got busy=%b expected 0", busy); end
  endtask

`ifdef TXRX_TX_CRC_EN
  task automatic test_crc();
    np = 0; push(8'h00);
    build_exp(1);
    run_frame(1);
    n_checks++;
    if (m_tv !== (PRE + 3) * 8 * CLK_DIV + 64 || m_bad !== 0) begin
      n_fail++; $display("FAIL crc_frame: got %0d cycles %0d bad expected %0d cycles 0 bad",
                         m_tv, m_bad, (PRE + 3) * 8 * CLK_DIV + 64);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_random();
    test_underrun();
    test_async_reset();
    test_back_to_back();
`ifdef TXRX_TX_CRC_EN
    test_crc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
